// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: RV32I opcodes, field widths, FSM states and the field-to-word packer.
package inst_encoder_pkg;
  localparam int INST_WIDTH = 32;
  localparam int NUM_REGISTER = 32;
  localparam int REG_W = $clog2(NUM_REGISTER);
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] FUNCT_7_ALT = 7'b0100000;
  typedef enum logic [1:0] {ENC_IDLE, ENC_RUN, ENC_DRAIN} state_t;
  function automatic logic op_known(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_ALUI, OP_ALU, OP_FENCE, OP_SYSTEM};
  endfunction
  function automatic logic [INST_WIDTH-1:0] encode(input logic [6:0] op, input logic [2:0] f3,
      input logic alt, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
      input logic [REG_W-1:0] rs2, input logic [31:0] imm);
    logic [6:0] f7;
    logic [INST_WIDTH-1:0] w;
    f7 = alt ? FUNCT_7_ALT : 7'b0;
    case (op)
      OP_ALU: w = {f7, rs2, rs1, f3, rd, op};
      // immediate shifts carry shamt in imm[4:0] and the SRAI selector in funct7
      OP_ALUI: w = (f3 == 3'b001 || f3 == 3'b101) ? {f7, imm[4:0], rs1, f3, rd, op}
                                                  : {imm[11:0], rs1, f3, rd, op};
      OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: w = {imm[11:0], rs1, f3, rd, op};
      OP_STORE: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      OP_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      OP_LUI, OP_AUIPC: w = {imm[31:12], rd, op};
      OP_JAL: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = '0;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field handshake, session control and imem write port of the encoder.
interface inst_encoder_if #(parameter int ADDR_W = 32);
  import inst_encoder_pkg::*;
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic valid, ready, last;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic alt;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [31:0] imm;
  logic imem_busy, imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_wdata;
  logic done, err;
  modport master(output start, base_addr, valid, last, opcode, funct3, alt, rd, rs1, rs2, imm,
                 imem_busy, input ready, imem_we, imem_addr, imem_wdata, done, err);
  modport slave(input start, base_addr, valid, last, opcode, funct3, alt, rd, rs1, rs2, imm,
                imem_busy, output ready, imem_we, imem_addr, imem_wdata, done, err);
endinterface

// File: rtl/inst_encoder_sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and a synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields into words, buffers them and streams them into imem.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst_n,
  inst_encoder_if.slave bus
);
  state_t state, next;
  logic [ADDR_W-1:0] addr;
  logic [INST_WIDTH-1:0] word, head;
  logic err, bad, fire, clr, full, empty;
  assign word = encode(bus.opcode, bus.funct3, bus.alt, bus.rd, bus.rs1, bus.rs2, bus.imm);
  assign bad = !op_known(bus.opcode) ||
               ((bus.opcode == OP_BRANCH || bus.opcode == OP_JAL) && bus.imm[0]);
  assign bus.ready = state == ENC_RUN && !full;
  assign fire = bus.valid && bus.ready;
  assign clr = state == ENC_IDLE && bus.start;
  assign bus.imem_we = state != ENC_IDLE && !empty && !bus.imem_busy;
  assign bus.imem_addr = addr;
  assign bus.imem_wdata = empty ? '0 : head;
  assign bus.done = state == ENC_DRAIN && empty;
  assign bus.err = err;
  always_comb begin
    next = state;
    next = clr ? ENC_RUN : (fire && bus.last) ? ENC_DRAIN : bus.done ? ENC_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ENC_IDLE;
      addr <= '0;
      err <= 1'b0;
    end else begin
      state <= next;
      addr <= clr ? bus.base_addr : bus.imem_we ? addr + ADDR_W'(4) : addr;
      err <= clr ? 1'b0 : err | (fire && bad);
    end
  end
  // erroneous fields complete the handshake but never reach the FIFO
  sync_fifo #(.WIDTH(INST_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(fire && !bad), .pop(bus.imem_we),
    .din(word), .dout(head), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized and directed checks of inst_encoder against a field-level model.
module tb_inst_encoder;
  typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} wr_t;
  logic clk = 0;
  logic rst_n;
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0;
  int g0, d0, last_hs;
  wr_t got[$];
  wr_t exp_q[$];
  logic [31:0] exp_addr;
  logic exp_err;
  logic [6:0] legal[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  inst_encoder_if #(.ADDR_W(32)) bus ();
  inst_encoder #(.DEPTH(4), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.imem_we) got.push_back('{cyc, bus.imem_addr, bus.imem_wdata});
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  function automatic logic ref_bad(input logic [6:0] op, input logic [31:0] imm);
    int known = 0;
    foreach (legal[i]) if (legal[i] == op) known = 1;
    return known == 0 || ((op == 7'h63 || op == 7'h6F) && imm[0]);
  endfunction

  function automatic logic [31:0] ref_word(input logic [6:0] op, input logic [2:0] f3, input logic alt,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] b, f7;
    b = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
    f7 = alt ? 32'h4000_0000 : 32'h0;
    case (op)
      7'h33: return b | f7;
      7'h13: return (f3 == 3'd1 || f3 == 3'd5) ? ((b & 32'h000F_FFFF) | ((imm & 31) << 20) | f7)
                                               : ((b & 32'h000F_FFFF) | (imm << 20));
      7'h03, 7'h67, 7'h0F, 7'h73: return (b & 32'h000F_FFFF) | (imm << 20);
      7'h23: return (b & 32'h01FF_F07F) | ((imm & 31) << 7) | (((imm >> 5) & 127) << 25);
      7'h63: return (b & 32'h01FF_F07F) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7)
                  | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      7'h37, 7'h17: return (b & 32'hFFF) | (imm & 32'hFFFF_F000);
      7'h6F: return (b & 32'hFFF) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                  | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [31:0] base);
    bus.start = 1;
    bus.base_addr = base;
    step();
    bus.start = 0;
    exp_addr = base;
    exp_err = 0;
    exp_q.delete();
    g0 = got.size();
    d0 = done_cnt;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic alt, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    int n = 0;
    bus.valid = 1; bus.opcode = op; bus.funct3 = f3; bus.alt = alt;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm; bus.last = last;
    @(negedge clk);
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL handshake_timeout ready=%b required 1", bus.ready);
    end
    last_hs = cyc;
    step();
    bus.valid = 0;
    bus.last = 0;
  endtask

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic alt, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    if (ref_bad(op, imm)) exp_err = 1;
    else begin
      exp_q.push_back('{0, exp_addr, ref_word(op, f3, alt, rd, rs1, rs2, imm)});
      exp_addr += 4;
    end
    send(op, f3, alt, rd, rs1, rs2, imm, last);
  endtask

  task automatic finish_session(input string name);
    int n = 0;
    while (done_cnt == d0 && n < 100) begin
      step();
      n++;
    end
    step(); step();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s done_pulses got %0d required 1", name, done_cnt - d0);
    end
    checks++;
    if (got.size() - g0 != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d required %0d", name, got.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i].addr !== exp_q[i].addr || got[g0+i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL %s write%0d got %h@%h required %h@%h", name, i, got[g0+i].data,
                 got[g0+i].addr, exp_q[i].data, exp_q[i].addr);
      end
    end
    checks++;
    if (bus.err !== exp_err) begin
      errors++;
      $display("FAIL %s err got %b required %b", name, bus.err, exp_err);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    checks++;
    if ({bus.ready, bus.imem_we, bus.done, bus.err} !== 4'b0 || bus.imem_addr !== 0 || bus.imem_wdata !== 0) begin
      errors++;
      $display("FAIL %s outputs got rdy=%b we=%b done=%b err=%b addr=%h wdata=%h required all 0",
               name, bus.ready, bus.imem_we, bus.done, bus.err, bus.imem_addr, bus.imem_wdata);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    step(); step();
    check_idle_outputs("reset");
    bus.valid = 1;
    check_idle_outputs("reset_valid_ignored");
    bus.valid = 0;
    rst_n = 1;
    step();
  endtask

  task automatic test_single();
    begin_session(32'h100);
    do_op(7'h13, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    finish_session("single");
    checks++;
    if (got.size() <= g0 || got[g0].data !== 32'h0050_0093 || done_cyc != got[g0].cyc + 1) begin
      errors++;
      $display("FAIL single_timing got done_cyc=%0d word=%h required done one cycle after 00500093",
               done_cyc, got.size() > g0 ? got[g0].data : 32'hx);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want[5] = '{32'h402081B3, 32'h4030D093, 32'h123452B7, 32'h00208463, 32'h010000EF};
    begin_session(32'h0);
    do_op(7'h33, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    do_op(7'h13, 3'd5, 1, 5'd1, 5'd1, 5'd0, 32'd3, 0);
    do_op(7'h37, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 0);
    do_op(7'h63, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd8, 0);
    do_op(7'h6F, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd16, 1);
    finish_session("stream");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got.size() <= g0 + i || got[g0+i].data !== want[i] || got[g0+i].addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_const%0d got %h required %h@%h", i,
                 got.size() > g0 + i ? got[g0+i].data : 32'hx, want[i], 4 * i);
      end
    end
  endtask

  task automatic test_busy_backpressure();
    begin_session(32'h200);
    bus.imem_busy = 1;
    for (int i = 0; i < 4; i++) do_op(7'h13, 3'd0, 0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 0);
    bus.valid = 1; bus.opcode = 7'h13;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.ready !== 0 || bus.imem_we !== 0 || bus.imem_wdata !== exp_q[0].data || bus.imem_addr !== 32'h200) begin
        errors++;
        $display("FAIL busy_full got rdy=%b we=%b wdata=%h addr=%h required 0 0 %h 00000200",
                 bus.ready, bus.imem_we, bus.imem_wdata, bus.imem_addr, exp_q[0].data);
      end
      step();
    end
    bus.imem_busy = 0;
    do_op(7'h13, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'd4, 0);
    do_op(7'h13, 3'd0, 0, 5'd6, 5'd0, 5'd0, 32'd5, 1);
    finish_session("busy");
  endtask

  task automatic test_errors();
    begin_session(32'h300);
    do_op(7'h7F, 3'd0, 0, 5'd1, 5'd2, 5'd3, 32'd9, 0);
    do_op(7'h13, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    finish_session("bad_opcode");
    step(); step();
    checks++;
    if (bus.imem_addr !== 32'h304 || bus.err !== 1) begin
      errors++;
      $display("FAIL err_sticky got addr=%h err=%b required 00000304 1", bus.imem_addr, bus.err);
    end
    begin_session(32'h400);
    @(negedge clk);
    checks++;
    if (bus.err !== 0) begin
      errors++;
      $display("FAIL err_clear_on_start got %b required 0", bus.err);
    end
    step();
    do_op(7'h63, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd7, 1);
    finish_session("beq_odd");
    checks++;
    if (done_cyc != last_hs + 1) begin
      errors++;
      $display("FAIL err_only_done got cycle %0d required %0d", done_cyc, last_hs + 1);
    end
  endtask

  task automatic test_wrap_and_restart();
    begin_session(32'hFFFF_FFF8);
    do_op(7'h23, 3'd2, 0, 5'd0, 5'd4, 5'd5, 32'hFFFF_FFFC, 0);
    bus.start = 1;
    bus.base_addr = 32'h500;
    do_op(7'h17, 3'd0, 0, 5'd7, 5'd0, 5'd0, 32'hABCD_E123, 0);
    bus.start = 0;
    do_op(7'h67, 3'd0, 0, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 1);
    finish_session("wrap");
  endtask

  task automatic test_random();
    logic stop;
    logic [6:0] op;
    logic [31:0] imm;
    for (int s = 0; s < 4; s++) begin
      begin_session({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      stop = 0;
      fork
        begin
          for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 19) == 0) ? 7'h7F : legal[$urandom_range(0, 10)];
            imm = $urandom;
            if ((op == 7'h63 || op == 7'h6F) && $urandom_range(0, 5) != 0) imm[0] = 0;
            do_op(op, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, i == 9);
          end
          stop = 1;
        end
        begin
          while (!stop) begin
            bus.imem_busy = $urandom_range(0, 2) == 0;
            step();
          end
          bus.imem_busy = 0;
        end
      join
      finish_session("random");
    end
  endtask

  task automatic test_reset_mid_session();
    int g1;
    begin_session(32'h600);
    bus.imem_busy = 1;
    for (int i = 0; i < 3; i++) do_op(7'h33, 3'(i), 0, 5'(i), 5'd1, 5'd2, 32'd0, 0);
    do_op(7'h7F, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
    @(negedge clk);
    checks++;
    if (bus.err !== 1 || bus.imem_wdata !== exp_q[0].data) begin
      errors++;
      $display("FAIL pre_reset got err=%b wdata=%h required 1 %h", bus.err, bus.imem_wdata, exp_q[0].data);
    end
    g1 = got.size();
    rst_n = 0;
    step();
    check_idle_outputs("mid_reset");
    rst_n = 1;
    bus.imem_busy = 0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (got.size() != g1) begin
      errors++;
      $display("FAIL post_reset_writes got %0d required 0", got.size() - g1);
    end
  endtask

  initial begin
    rst_n = 0;
    bus.start = 0; bus.base_addr = 0; bus.valid = 0; bus.last = 0; bus.opcode = 0; bus.funct3 = 0;
    bus.alt = 0; bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0; bus.imem_busy = 0;
    test_reset();
    test_single();
    test_stream();
    test_busy_backpressure();
    test_errors();
    test_wrap_and_restart();
    test_random();
    test_reset_mid_session();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
